// File: rtl/jtframe_logo_pkg.sv
// Logo overlay sequencer: shared state encoding and sizes.
// Imported by the interface, the frame counter and the top.
package jtframe_logo_pkg;

  localparam int LOGO_AW        = 11;
  localparam int LOGO_BYTES_DEF = 2048;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SHOW = 2'd2,
    DONE = 2'd3
  } logo_st_t;

endpackage

// File: rtl/jtframe_logo_ctrl_if.sv
// Download bus into the sequencer and logo ROM write port out of it.
// master = download side, slave = sequencer.
interface jtframe_logo_ctrl_if;
  import jtframe_logo_pkg::*;

  logic               dwn_en;
  logic [LOGO_AW-1:0] dwn_addr;
  logic [7:0]         dwn_data;
  logic               dwn_we;
  logic [LOGO_AW-1:0] prog_addr;
  logic [7:0]         prog_data;
  logic               prog_we;

  modport master (
    output dwn_en, dwn_addr, dwn_data, dwn_we,
    input  prog_addr, prog_data, prog_we
  );

  modport slave (
    input  dwn_en, dwn_addr, dwn_data, dwn_we,
    output prog_addr, prog_data, prog_we
  );

endinterface

// File: rtl/jtframe_logo_frmcnt.sv
// Frame pulse from the rising edge of vs (pxl_cen qualified)
// and an 8-bit saturating frame counter with clear.
module jtframe_logo_frmcnt (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pxl_cen,
  input  logic       vs,
  input  logic       clr,
  input  logic       inc,
  output logic       frame,
  output logic [7:0] cnt
);

  logic vsl;

  assign frame = pxl_cen & vs & ~vsl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsl <= 1'b0;
      cnt <= '0;
    end else begin
      if (pxl_cen) vsl <= vs;
      if (clr)
        cnt <= '0;
      else if (inc && cnt != 8'hff)
        cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/jtframe_logo_ctrl.sv
// Logo sequencer: forwards download bytes to the logo ROM and
// shows the logo for a bounded number of frames after a full load.
module jtframe_logo_ctrl
  import jtframe_logo_pkg::*;
#(
  parameter int LOGO_BYTES  = LOGO_BYTES_DEF,
  parameter int SHOW_FRAMES = 180,
  parameter int MIN_FRAMES  = 30
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pxl_cen,
  input  logic vs,
  input  logic enable,
  input  logic dismiss,
  jtframe_logo_ctrl_if.slave bus,
  output logic show_en,
  output logic busy,
  output logic logo_ok
);

  logo_st_t    st, st_nxt;
  logic        show_nxt, ok_nxt;
  logic        dl, rise, fall, acc, full;
  logic [11:0] bcnt;
  logic        frame, fr_clr, fr_inc;
  logic [7:0]  fr_cnt;
  logic [8:0]  fr_n;

  assign acc  = bus.dwn_en & bus.dwn_we;
  assign rise = bus.dwn_en & ~dl;
  assign fall = ~bus.dwn_en & dl;
  assign full = bcnt == 12'(LOGO_BYTES);
  assign busy = (st == LOAD) || (st == SHOW);
  // index of the current frame counted from the one that raised show_en
  assign fr_n = {1'b0, fr_cnt} + 9'd1;

  jtframe_logo_frmcnt u_frmcnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .pxl_cen (pxl_cen),
    .vs      (vs),
    .clr     (fr_clr),
    .inc     (fr_inc),
    .frame   (frame),
    .cnt     (fr_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.prog_addr <= '0;
      bus.prog_data <= '0;
      bus.prog_we   <= 1'b0;
      dl            <= 1'b0;
      bcnt          <= '0;
    end else begin
      bus.prog_addr <= bus.dwn_addr;
      bus.prog_data <= bus.dwn_data;
      bus.prog_we   <= acc;
      dl            <= bus.dwn_en;
      if (rise)
        bcnt <= {11'd0, acc};
      else if (acc && !full)
        bcnt <= bcnt + 12'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= IDLE;
      show_en <= 1'b0;
      logo_ok <= 1'b0;
    end else begin
      st      <= st_nxt;
      show_en <= show_nxt;
      logo_ok <= ok_nxt;
    end
  end

  always_comb begin
    st_nxt   = st;
    show_nxt = show_en;
    ok_nxt   = logo_ok;
    fr_clr   = 1'b0;
    fr_inc   = 1'b0;
    unique case (st)
      IDLE: begin
        if (rise) begin
          st_nxt = LOAD;
          ok_nxt = 1'b0;
        end
      end
      LOAD: begin
        if (fall) begin
          ok_nxt = full;
          st_nxt = (full && enable) ? SHOW : DONE;
        end
      end
      SHOW: begin
        // a new download must never see the overlay reading the ROM
        if (rise) begin
          st_nxt   = LOAD;
          show_nxt = 1'b0;
          ok_nxt   = 1'b0;
        end else if (frame) begin
          if (!show_en) begin
            show_nxt = 1'b1;
            fr_clr   = 1'b1;
          end else if (fr_n == 9'(SHOW_FRAMES) ||
                       (dismiss && fr_n >= 9'(MIN_FRAMES))) begin
            show_nxt = 1'b0;
            st_nxt   = DONE;
          end else begin
            fr_inc = 1'b1;
          end
        end
      end
      DONE: begin
        show_nxt = 1'b0;
        if (rise) begin
          st_nxt = LOAD;
          ok_nxt = 1'b0;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_jtframe_logo_ctrl.sv
// Bench for jtframe_logo_ctrl: event-level model checked every cycle
// plus hand-computed frame/byte totals for each scenario.
module tb_jtframe_logo_ctrl;
  import jtframe_logo_pkg::*;

  localparam int LB = 2048;
  localparam int SF = 180;
  localparam int MF = 30;
  localparam int FP = 24;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pxl_cen = 1'b0;
  logic vs = 1'b0;
  logic enable = 1'b1;
  logic dismiss = 1'b0;
  logic show_en, busy, logo_ok;

  jtframe_logo_ctrl_if bus();

  jtframe_logo_ctrl #(
    .LOGO_BYTES  (LB),
    .SHOW_FRAMES (SF),
    .MIN_FRAMES  (MF)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .pxl_cen (pxl_cen),
    .vs      (vs),
    .enable  (enable),
    .dismiss (dismiss),
    .bus     (bus),
    .show_en (show_en),
    .busy    (busy),
    .logo_ok (logo_ok)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) begin
    #1;
    cyc++;
    pxl_cen = 1'((cyc & 1));
    vs = ((cyc % FP) >= 1) && ((cyc % FP) <= 4);
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad < 25)
        $display("FAIL %s at cyc %0d: got %0h want %0h",
                 nm, cyc, act, exp);
    end
  endtask

  task automatic tmo(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out at cyc %0d", nm, cyc);
  endtask

  // behavioural model, advanced with the inputs seen at each edge
  logic [10:0] m_addr;
  logic [7:0]  m_data;
  bit m_we, m_show, m_ok, m_load, m_arm, m_vsl, m_den;
  int m_bytes, m_frames;
  int frame_no = 0;
  int hi_total = 0;
  int we_total = 0;

  always @(negedge clk) begin
    bit fr, rise, fall, acc;
    if (!rst_n) begin
      m_addr = '0; m_data = '0; m_we = 0;
      m_show = 0; m_ok = 0; m_load = 0; m_arm = 0;
      m_vsl = 0; m_den = 0; m_bytes = 0; m_frames = 0;
    end
    chk("prog_addr", 32'(bus.prog_addr), 32'(m_addr));
    chk("prog_data", 32'(bus.prog_data), 32'(m_data));
    chk("prog_we", 32'(bus.prog_we), 32'(m_we));
    chk("show_en", 32'(show_en), 32'(m_show));
    chk("busy", 32'(busy), 32'(m_load || m_arm));
    chk("logo_ok", 32'(logo_ok), 32'(m_ok));
    if (show_en) hi_total++;
    if (bus.prog_we) we_total++;
    if (rst_n) begin
      fr = pxl_cen && vs && !m_vsl;
      if (pxl_cen) m_vsl = vs;
      if (fr) frame_no++;
      rise = bus.dwn_en && !m_den;
      fall = !bus.dwn_en && m_den;
      m_den = bus.dwn_en;
      acc = bus.dwn_en && bus.dwn_we;
      if (m_load) begin
        if (fall) begin
          m_load = 0;
          m_ok = (m_bytes >= LB);
          m_arm = m_ok && enable;
        end
      end else if (rise) begin
        m_load = 1; m_arm = 0; m_show = 0; m_ok = 0;
      end else if (m_arm && fr) begin
        if (!m_show) begin
          m_show = 1;
          m_frames = 0;
        end else begin
          m_frames++;
          if (m_frames == SF || (dismiss && m_frames >= MF)) begin
            m_show = 0;
            m_arm = 0;
          end
        end
      end
      if (rise) m_bytes = int'(acc);
      else if (acc) m_bytes++;
      m_addr = bus.dwn_addr;
      m_data = bus.dwn_data;
      m_we = acc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int n, input int gap);
    tick();
    bus.dwn_en = 1'b1;
    bus.dwn_we = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (i == 0) begin
        chk("load_entry_busy", 32'(busy), 32'd1);
        chk("load_entry_ok", 32'(logo_ok), 32'd0);
        chk("load_entry_show", 32'(show_en), 32'd0);
      end
      bus.dwn_we = 1'b1;
      bus.dwn_addr = 11'(i);
      bus.dwn_data = 8'(i);
      for (int g = 0; g < gap; g++) begin
        tick();
        bus.dwn_we = 1'b0;
        bus.dwn_addr = 11'($urandom);
        bus.dwn_data = 8'($urandom);
      end
    end
    tick();
    bus.dwn_we = 1'b0;
    tick();
    bus.dwn_en = 1'b0;
    bus.dwn_we = 1'b1;
    bus.dwn_addr = 11'h5a5;
    bus.dwn_data = 8'hc3;
    tick();
    bus.dwn_we = 1'b0;
  endtask

  task automatic wait_show(input bit want, input int max, input string nm);
    int n = 0;
    while (show_en !== want && n < max) begin
      tick();
      n++;
    end
    if (show_en !== want) tmo(nm);
  endtask

  task automatic wait_fn(input int target, input string nm);
    int n = 0;
    while (frame_no < target && n < 400 * FP) begin
      tick();
      n++;
    end
    if (frame_no < target) tmo(nm);
  endtask

  int h0, w0, base;

  initial begin
    bus.dwn_en = 1'b0;
    bus.dwn_we = 1'b0;
    bus.dwn_addr = '0;
    bus.dwn_data = '0;
    repeat (3) tick();
    chk("reset_state", 32'({show_en, busy, logo_ok, bus.prog_we,
        bus.prog_addr, bus.prog_data}), 32'd0);
    rst_n = 1'b1;
    repeat (4) tick();

    w0 = we_total;
    do_load(LB, 1);
    chk("full_we_pulses", 32'(we_total - w0), 32'd2048);
    chk("full_logo_ok", 32'(logo_ok), 32'd1);
    chk("full_busy", 32'(busy), 32'd1);
    wait_show(1, 3 * FP, "full_rise");
    h0 = hi_total;
    wait_show(0, SF * FP + 100, "full_fall");
    chk("full_hi_cycles", 32'(hi_total - h0), 32'(180 * 24));
    tick();
    chk("full_done_busy", 32'(busy), 32'd0);

    do_load(LB - 1, 0);
    chk("short_logo_ok", 32'(logo_ok), 32'd0);
    chk("short_busy", 32'(busy), 32'd0);
    h0 = hi_total;
    repeat (40 * FP) tick();
    chk("short_hi_cycles", 32'(hi_total - h0), 32'd0);

    do_load(LB, 0);
    wait_show(1, 3 * FP, "dism10_rise");
    base = frame_no;
    h0 = hi_total;
    wait_fn(base + 10, "dism10_wait");
    dismiss = 1'b1;
    wait_show(0, SF * FP + 100, "dism10_fall");
    chk("dism10_hi_cycles", 32'(hi_total - h0), 32'(30 * 24));
    dismiss = 1'b0;

    do_load(LB, 0);
    wait_show(1, 3 * FP, "dism100_rise");
    base = frame_no;
    h0 = hi_total;
    wait_fn(base + 100, "dism100_wait");
    repeat (5) tick();
    dismiss = 1'b1;
    wait_show(0, SF * FP + 100, "dism100_fall");
    chk("dism100_hi_cycles", 32'(hi_total - h0), 32'(101 * 24));
    dismiss = 1'b0;

    do_load(LB, 0);
    wait_show(1, 3 * FP, "redl_rise");
    base = frame_no;
    wait_fn(base + 60, "redl_wait");
    do_load(LB, 0);
    chk("redl_logo_ok", 32'(logo_ok), 32'd1);
    wait_show(1, 3 * FP, "redl_rise2");
    h0 = hi_total;
    wait_show(0, SF * FP + 100, "redl_fall2");
    chk("redl_hi_cycles", 32'(hi_total - h0), 32'(180 * 24));

    enable = 1'b0;
    w0 = we_total;
    do_load(LB, 0);
    chk("noen_we_pulses", 32'(we_total - w0), 32'd2048);
    chk("noen_logo_ok", 32'(logo_ok), 32'd1);
    chk("noen_busy", 32'(busy), 32'd0);
    h0 = hi_total;
    repeat (300 * FP) tick();
    chk("noen_hi_cycles", 32'(hi_total - h0), 32'd0);
    enable = 1'b1;

    do_load(LB, 0);
    wait_show(1, 3 * FP, "rst_rise");
    base = frame_no;
    wait_fn(base + 50, "rst_wait");
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("rst_async", 32'({show_en, busy, logo_ok, bus.prog_we,
        bus.prog_addr, bus.prog_data}), 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (5 * FP) tick();
    chk("rst_idle_busy", 32'(busy), 32'd0);
    chk("rst_idle_show", 32'(show_en), 32'd0);

    do_load(LB, 0);
    chk("post_rst_ok", 32'(logo_ok), 32'd1);
    wait_show(1, 3 * FP, "post_rst_rise");
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
